// File: rtl/adder_defs_pkg.sv
// Shared definitions for the chunked serial adder: FSM state encodings and
// the index-counter width helper.
package adder_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A counter for n chunks needs $clog2(n) bits, but never fewer than one.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunk_ripple_adder.sv
// CHUNK-bit combinational ripple slice built from full_adder cells.
// Zero latency; no handshake, purely combinational.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);
endmodule

module chunk_ripple_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);
  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .x  (x[i]),
      .y  (y[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co = c[CHUNK];
endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle add/sub: WIDTH-bit operands through one CHUNK-bit slice, out_valid NUM_CHUNKS edges after accept.
// Result is held in DONE until out_ready; in_ready follows out_ready there so retire and accept can share an edge.
module chunked_serial_adder
  import adder_defs::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int IDXW       = idx_width(NUM_CHUNKS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_CHUNKS - 1);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("chunked_serial_adder: WIDTH must be a multiple of CHUNK and 1 <= CHUNK <= WIDTH");
  end

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  a_q, b_q, sum_q;
  logic              carry_q, cout_q, ovf_q;
  logic [CHUNK-1:0]  a_chunk, b_chunk, s_chunk;
  logic              co_chunk;
  logic              last_chunk;
  logic              accept;

  assign a_chunk    = a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign b_chunk    = b_q[int'(idx_q)*CHUNK +: CHUNK];
  assign last_chunk = (idx_q == LAST_IDX);
  assign accept     = in_valid && in_ready;

  chunk_ripple_adder #(.CHUNK(CHUNK)) u_slice (
    .x  (a_chunk),
    .y  (b_chunk),
    .ci (carry_q),
    .s  (s_chunk),
    .co (co_chunk)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (last_chunk) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_d = in_valid ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        // Subtraction is a + ~b + 1, so the slice never needs to know the mode.
        a_q     <= a;
        b_q     <= sub ? ~b : b;
        carry_q <= sub ? 1'b1 : cin;
        idx_q   <= '0;
      end else if (state_q == ST_RUN) begin
        sum_q[int'(idx_q)*CHUNK +: CHUNK] <= s_chunk;
        carry_q <= co_chunk;
        idx_q   <= last_chunk ? '0 : idx_q + IDXW'(1);
        if (last_chunk) begin
          cout_q <= co_chunk;
          ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_chunk[CHUNK-1] != a_q[WIDTH-1]);
        end
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder: three instances (CHUNK 4, 16, 1) on one clock,
// each with its own handshake, checked against a signed/unsigned arithmetic model.
module tb_chunked_serial_adder;

  logic        clk;
  logic        rst_n;
  logic [15:0] a, b;
  logic        sub, cin;
  logic [2:0]  in_valid, out_ready;
  logic [2:0]  in_ready_w, out_valid_w, cout_w, ovf_w;
  logic [15:0] sum_w [3];

  int lat_exp [3] = '{4, 1, 16};
  int checks = 0;
  int passes = 0;
  int fails  = 0;

  chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid_w[0]), .out_ready(out_ready[0]),
    .sum(sum_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0]));

  chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid_w[1]), .out_ready(out_ready[1]),
    .sum(sum_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1]));

  chunked_serial_adder #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid_w[2]), .out_ready(out_ready[2]),
    .sum(sum_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic. Returns {ovf, cout, sum}.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic s, input logic c);
    longint ux, uy, sx, sy, ures, sres, ci;
    logic   co, ov;
    logic [15:0] r;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ci = c ? 64'sd1 : 64'sd0;
    if (s) begin
      ures = ux - uy;
      co   = (ux >= uy);
      sres = sx - sy;
    end else begin
      ures = ux + uy + ci;
      co   = (ures > 65535);
      sres = sx + sy + ci;
    end
    r  = ures[15:0];
    ov = (sres > 32767) || (sres < -32768);
    return {ov, co, r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    a   = 16'($urandom);
    b   = 16'($urandom);
    sub = 1'($urandom);
    cin = 1'($urandom);
  endtask

  // Waits (bounded) for out_valid on instance k; returns edges waited and whether it rose.
  task automatic wait_valid(input int k, output int lat, output bit got);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      if (out_valid_w[k] === 1'b1) got = 1'b1;
      else begin
        step();
        lat++;
      end
    end
  endtask

  // One full operation on instance k with out_ready high; starts and ends #1 after an edge.
  task automatic drive_and_check(input int k, input logic [15:0] ta, input logic [15:0] tb_v,
                                 input logic ts, input logic tc, input string tag);
    logic [17:0] exp_r;
    int lat;
    bit got;
    exp_r = model(ta, tb_v, ts, tc);
    a = ta; b = tb_v; sub = ts; cin = tc;
    in_valid[k] = 1'b1;
    #1;
    checks++;
    if (in_ready_w[k] !== 1'b1) begin
      fails++; $display("FAIL %s in_ready dut%0d got %b want 1", tag, k, in_ready_w[k]);
    end else passes++;
    step();
    in_valid[k] = 1'b0;
    scramble();
    wait_valid(k, lat, got);
    checks++;
    if (!got) begin
      fails++; $display("FAIL %s timeout dut%0d out_valid never rose", tag, k);
    end else if (lat != lat_exp[k]) begin
      fails++; $display("FAIL %s latency dut%0d got %0d want %0d", tag, k, lat, lat_exp[k]);
    end else passes++;
    checks++;
    if ({ovf_w[k], cout_w[k], sum_w[k]} !== exp_r) begin
      fails++;
      $display("FAIL %s result dut%0d a=%h b=%h sub=%b cin=%b got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
               tag, k, ta, tb_v, ts, tc, ovf_w[k], cout_w[k], sum_w[k], exp_r[17], exp_r[16], exp_r[15:0]);
    end else passes++;
    step();
    checks++;
    if (out_valid_w[k] !== 1'b0) begin
      fails++; $display("FAIL %s retire dut%0d out_valid got %b want 0", tag, k, out_valid_w[k]);
    end else passes++;
  endtask

  task automatic test_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({out_valid_w[k], cout_w[k], ovf_w[k], sum_w[k]} !== 19'd0) begin
        fails++; $display("FAIL reset_outputs dut%0d got ov=%b c=%b o=%b s=%h want all 0",
                          k, out_valid_w[k], cout_w[k], ovf_w[k], sum_w[k]);
      end else passes++;
    end
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready_w !== 3'b111) begin
      fails++; $display("FAIL reset_in_ready got %b want 111", in_ready_w);
    end else passes++;
    step();
  endtask

  task automatic test_add();
    drive_and_check(0, 16'h1234, 16'h0FED, 1'b0, 1'b0, "add");
  endtask

  task automatic test_carry_chain();
    drive_and_check(0, 16'hFFFF, 16'h0000, 1'b0, 1'b1, "carry_ffff");
    drive_and_check(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, "carry_ovf");
  endtask

  task automatic test_subtract();
    drive_and_check(0, 16'h0005, 16'h0007, 1'b1, 1'b0, "sub_borrow");
    drive_and_check(0, 16'h8000, 16'h0001, 1'b1, 1'b1, "sub_ovf");
  endtask

  task automatic test_backpressure();
    logic [17:0] exp1, exp2;
    int lat;
    bit got;
    exp1 = model(16'hBEEF, 16'h1234, 1'b0, 1'b1);
    exp2 = model(16'h4321, 16'h9876, 1'b1, 1'b0);
    out_ready[0] = 1'b0;
    a = 16'hBEEF; b = 16'h1234; sub = 1'b0; cin = 1'b1;
    in_valid[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    scramble();
    wait_valid(0, lat, got);
    checks++;
    if (!got || lat != 4) begin
      fails++; $display("FAIL bp_latency got %0d (seen %b) want 4", lat, got);
    end else passes++;
    for (int i = 0; i < 5; i++) begin
      scramble();
      step();
      checks++;
      if ({out_valid_w[0], in_ready_w[0], ovf_w[0], cout_w[0], sum_w[0]} !== {1'b1, 1'b0, exp1}) begin
        fails++; $display("FAIL bp_hold cycle %0d got v=%b r=%b o=%b c=%b s=%h want v=1 r=0 o=%b c=%b s=%h",
                          i, out_valid_w[0], in_ready_w[0], ovf_w[0], cout_w[0], sum_w[0],
                          exp1[17], exp1[16], exp1[15:0]);
      end else passes++;
    end
    a = 16'h4321; b = 16'h9876; sub = 1'b1; cin = 1'b0;
    in_valid[0] = 1'b1;
    out_ready[0] = 1'b1;
    #1;
    checks++;
    if (in_ready_w[0] !== 1'b1) begin
      fails++; $display("FAIL bp_in_ready_follow got %b want 1", in_ready_w[0]);
    end else passes++;
    step();
    in_valid[0] = 1'b0;
    scramble();
    wait_valid(0, lat, got);
    checks++;
    if (!got || lat != 4) begin
      fails++; $display("FAIL bp_second_latency got %0d (seen %b) want 4", lat, got);
    end else passes++;
    checks++;
    if ({ovf_w[0], cout_w[0], sum_w[0]} !== exp2) begin
      fails++; $display("FAIL bp_second_result got o=%b c=%b s=%h want o=%b c=%b s=%h",
                        ovf_w[0], cout_w[0], sum_w[0], exp2[17], exp2[16], exp2[15:0]);
    end else passes++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [15:0] xa [5], xb [5];
    logic        xs [5], xc [5];
    logic [17:0] exp_r;
    int lat;
    bit got;
    for (int i = 0; i < 5; i++) begin
      xa[i] = 16'($urandom); xb[i] = 16'($urandom);
      xs[i] = 1'($urandom);  xc[i] = 1'($urandom);
    end
    a = xa[0]; b = xb[0]; sub = xs[0]; cin = xc[0];
    in_valid[0] = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = 1'b0;
      scramble();
      wait_valid(0, lat, got);
      exp_r = model(xa[i], xb[i], xs[i], xc[i]);
      checks++;
      if (!got || lat != 4 || {ovf_w[0], cout_w[0], sum_w[0]} !== exp_r) begin
        fails++; $display("FAIL b2b op %0d lat=%0d seen=%b got o=%b c=%b s=%h want lat=4 o=%b c=%b s=%h",
                          i, lat, got, ovf_w[0], cout_w[0], sum_w[0], exp_r[17], exp_r[16], exp_r[15:0]);
      end else passes++;
      if (i < 4) begin
        a = xa[i+1]; b = xb[i+1]; sub = xs[i+1]; cin = xc[i+1];
        in_valid[0] = 1'b1;
        #1;
        checks++;
        if (in_ready_w[0] !== 1'b1) begin
          fails++; $display("FAIL b2b accept op %0d in_ready got %b want 1", i + 1, in_ready_w[0]);
        end else passes++;
      end
      step();
    end
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    a = 16'hA5A5; b = 16'h5A5A; sub = 1'b0; cin = 1'b1;
    in_valid[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid_w[0], cout_w[0], ovf_w[0], sum_w[0]} !== 19'd0) begin
      fails++; $display("FAIL midreset_outputs got v=%b c=%b o=%b s=%h want all 0",
                        out_valid_w[0], cout_w[0], ovf_w[0], sum_w[0]);
    end else passes++;
    step();
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid_w[0] === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      fails++; $display("FAIL midreset_no_emit out_valid rose got 1 want 0");
    end else passes++;
    drive_and_check(0, 16'h0F0F, 16'h00F1, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_sweep();
    drive_and_check(1, 16'h1234, 16'h0FED, 1'b0, 1'b0, "chunk16_add");
    drive_and_check(2, 16'h1234, 16'h0FED, 1'b0, 1'b0, "chunk1_add");
    drive_and_check(2, 16'h8000, 16'h0001, 1'b1, 1'b0, "chunk1_sub");
    for (int i = 0; i < 1000; i++) begin
      drive_and_check(int'($urandom_range(0, 2)), 16'($urandom), 16'($urandom),
                      1'($urandom), 1'($urandom), "random");
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 3'b000;
    out_ready = 3'b111;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    step();
    test_reset();
    test_add();
    test_carry_chain();
    test_subtract();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    test_sweep();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
